// File: rtl/calc_sequencer_gen_pkg.sv
// Shared types and constants for the keypad calculator sequencer.
// Covers FSM states, keypad codes, error codes and key classification helpers.
package calc_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ENTER_A,
    S_WRITE_A,
    S_ENTER_OP,
    S_ENTER_B,
    S_WRITE_B,
    S_EXEC,
    S_WAIT_ALU,
    S_WRITE_R,
    S_SHOW,
    S_READBACK
  } state_t;

  typedef logic [3:0] op_t;

  localparam op_t KEY_ADD = 4'hA;
  localparam op_t KEY_SUB = 4'hB;
  localparam op_t KEY_AND = 4'hC;
  localparam op_t KEY_OR  = 4'hD;
  localparam op_t KEY_SHL = 4'hE;
  localparam op_t KEY_EQ  = 4'hF;

  localparam logic [2:0] ERR_NONE    = 3'b000;
  localparam logic [2:0] ERR_DIGIT   = 3'b001;
  localparam logic [2:0] ERR_KEY     = 3'b010;
  localparam logic [2:0] ERR_TIMEOUT = 3'b100;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

  function automatic logic is_op(input logic [3:0] code);
    return (code >= KEY_ADD) && (code <= KEY_SHL);
  endfunction

endpackage

// File: rtl/calc_sequencer_gen_if.sv
// Bundle of keypad, register-file, ALU and display signals around the sequencer.
// The sequencer takes the master side; the surrounding blocks take the slave side.
interface calc_sequencer_gen_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
);

  logic              mode_pi;
  logic              key_valid_pi;
  logic [3:0]        key_code_pi;
  logic              rf_we_o;
  logic [ADDR_W-1:0] rf_waddr_o;
  logic [DATA_W-1:0] rf_wdata_o;
  logic [ADDR_W-1:0] rf_raddr1_o;
  logic [ADDR_W-1:0] rf_raddr2_o;
  logic [DATA_W-1:0] rf_rdata1_pi;
  logic [3:0]        alu_op_o;
  logic              alu_start_o;
  logic              alu_done_pi;
  logic [DATA_W-1:0] alu_result_pi;
  logic [DATA_W-1:0] display_value_o;
  logic              display_en_o;
  logic [2:0]        error_code_o;
  logic              busy_o;

  modport master (
    input  mode_pi, key_valid_pi, key_code_pi, rf_rdata1_pi, alu_done_pi, alu_result_pi,
    output rf_we_o, rf_waddr_o, rf_wdata_o, rf_raddr1_o, rf_raddr2_o, alu_op_o,
           alu_start_o, display_value_o, display_en_o, error_code_o, busy_o
  );

  modport slave (
    output mode_pi, key_valid_pi, key_code_pi, rf_rdata1_pi, alu_done_pi, alu_result_pi,
    input  rf_we_o, rf_waddr_o, rf_wdata_o, rf_raddr1_o, rf_raddr2_o, alu_op_o,
           alu_start_o, display_value_o, display_en_o, error_code_o, busy_o
  );

endinterface

// File: rtl/calc_sequencer_gen_acc.sv
// Decimal operand accumulator: load starts a new operand, push appends a digit.
// acc_next is exposed so the sequencer can register the display in the same cycle.
module calc_operand_acc #(
  parameter int DATA_W     = 16,
  parameter int NUM_DIGITS = 4,
  localparam int CNT_W     = $clog2(NUM_DIGITS + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic              push,
  input  logic [3:0]        digit,
  output logic [DATA_W-1:0] acc,
  output logic [DATA_W-1:0] acc_next,
  output logic [CNT_W-1:0]  digit_cnt,
  output logic              full
);

  logic [CNT_W-1:0] cnt_next;

  assign full = (digit_cnt == CNT_W'(NUM_DIGITS));

  // Digits beyond NUM_DIGITS are dropped; the sequencer flags that case itself.
  always_comb begin
    acc_next = acc;
    cnt_next = digit_cnt;
    if (load) begin
      acc_next = DATA_W'(digit);
      cnt_next = CNT_W'(1);
    end else if (push && !full) begin
      acc_next = acc * DATA_W'(10) + DATA_W'(digit);
      cnt_next = digit_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc       <= '0;
      digit_cnt <= '0;
    end else begin
      acc       <= acc_next;
      digit_cnt <= cnt_next;
    end
  end

endmodule

// File: rtl/calc_sequencer_gen.sv
// Keypad calculator sequencer: builds operands, stores them in the register file,
// runs the external ALU, writes back and chains results, and walks stored entries.
module calc_sequencer_gen
  import calc_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 5,
  parameter int NUM_DIGITS  = 4,
  parameter int ALU_TIMEOUT = 64
) (
  input logic                clk,
  input logic                reset_n_pi,
  calc_sequencer_gen_if.master bus
);

  localparam int CNT_W = $clog2(NUM_DIGITS + 1);
  localparam int TMR_W = $clog2(ALU_TIMEOUT + 1);

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] a_addr;
  logic [ADDR_W-1:0] b_addr;
  op_t               op;
  logic [DATA_W-1:0] result;
  logic [TMR_W-1:0]  timer;

  logic              key_digit;
  logic              key_op;
  logic              key_eq;
  logic              acc_load;
  logic              acc_push;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] acc_next;
  logic [CNT_W-1:0]  digit_cnt;
  logic              acc_full;

  // Address 0 is reserved, so both pointers wrap around it.
  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return (a == {ADDR_W{1'b1}}) ? ADDR_W'(1) : a + ADDR_W'(1);
  endfunction

  function automatic logic [ADDR_W-1:0] addr_dec(input logic [ADDR_W-1:0] a);
    return (a <= ADDR_W'(1)) ? {ADDR_W{1'b1}} : a - ADDR_W'(1);
  endfunction

  assign key_digit = bus.key_valid_pi && is_digit(bus.key_code_pi);
  assign key_op    = bus.key_valid_pi && is_op(bus.key_code_pi);
  assign key_eq    = bus.key_valid_pi && (bus.key_code_pi == KEY_EQ);

  assign acc_load = key_digit && ((state == S_ENTER_OP) ||
                    (bus.mode_pi && ((state == S_IDLE) || (state == S_SHOW))));
  assign acc_push = key_digit && ((state == S_ENTER_A) || (state == S_ENTER_B));

  calc_operand_acc #(
    .DATA_W    (DATA_W),
    .NUM_DIGITS(NUM_DIGITS)
  ) u_acc (
    .clk      (clk),
    .reset_n  (reset_n_pi),
    .load     (acc_load),
    .push     (acc_push),
    .digit    (bus.key_code_pi),
    .acc      (acc),
    .acc_next (acc_next),
    .digit_cnt(digit_cnt),
    .full     (acc_full)
  );

  always_ff @(posedge clk or negedge reset_n_pi) begin
    if (!reset_n_pi) begin
      state               <= S_IDLE;
      wr_ptr              <= ADDR_W'(1);
      rd_ptr              <= '0;
      a_addr              <= '0;
      b_addr              <= '0;
      op                  <= '0;
      result              <= '0;
      timer               <= '0;
      bus.rf_we_o         <= 1'b0;
      bus.rf_waddr_o      <= '0;
      bus.rf_wdata_o      <= '0;
      bus.rf_raddr1_o     <= '0;
      bus.rf_raddr2_o     <= '0;
      bus.alu_op_o        <= '0;
      bus.alu_start_o     <= 1'b0;
      bus.display_value_o <= '0;
      bus.display_en_o    <= 1'b0;
      bus.error_code_o    <= ERR_NONE;
      bus.busy_o          <= 1'b0;
    end else begin
      bus.rf_we_o     <= 1'b0;
      bus.alu_start_o <= 1'b0;
      unique case (state)
        S_IDLE, S_SHOW: begin
          if (!bus.mode_pi) begin
            state           <= S_READBACK;
            rd_ptr          <= addr_dec(wr_ptr);
            bus.rf_raddr1_o <= addr_dec(wr_ptr);
          end else if (key_digit) begin
            state               <= S_ENTER_A;
            bus.display_value_o <= acc_next;
            bus.display_en_o    <= 1'b1;
            bus.error_code_o    <= ERR_NONE;
          end else if (key_op && state == S_SHOW) begin
            state            <= S_ENTER_OP;
            op               <= bus.key_code_pi;
            bus.error_code_o <= ERR_NONE;
          end else if (bus.key_valid_pi) begin
            bus.error_code_o <= ERR_KEY;
          end
        end
        S_ENTER_A, S_ENTER_B: begin
          if (key_digit) begin
            if (acc_full) begin
              bus.error_code_o <= ERR_DIGIT;
            end else begin
              bus.display_value_o <= acc_next;
              bus.display_en_o    <= 1'b1;
              bus.error_code_o    <= ERR_NONE;
            end
          end else if ((key_op && state == S_ENTER_A) ||
                       (key_eq && state == S_ENTER_B && digit_cnt != '0)) begin
            state            <= (state == S_ENTER_A) ? S_WRITE_A : S_WRITE_B;
            if (state == S_ENTER_A) op <= bus.key_code_pi;
            bus.rf_we_o      <= 1'b1;
            bus.rf_waddr_o   <= wr_ptr;
            bus.rf_wdata_o   <= acc;
            bus.busy_o       <= 1'b1;
            bus.error_code_o <= ERR_NONE;
          end else if (bus.key_valid_pi) begin
            bus.error_code_o <= ERR_KEY;
          end
        end
        S_WRITE_A: begin
          a_addr     <= wr_ptr;
          wr_ptr     <= addr_inc(wr_ptr);
          bus.busy_o <= 1'b0;
          state      <= S_ENTER_OP;
        end
        S_ENTER_OP: begin
          if (key_digit) begin
            state               <= S_ENTER_B;
            bus.display_value_o <= acc_next;
            bus.display_en_o    <= 1'b1;
            bus.error_code_o    <= ERR_NONE;
          end else if (key_op) begin
            op               <= bus.key_code_pi;
            bus.error_code_o <= ERR_NONE;
          end else if (bus.key_valid_pi) begin
            bus.error_code_o <= ERR_KEY;
          end
        end
        S_WRITE_B: begin
          b_addr <= wr_ptr;
          wr_ptr <= addr_inc(wr_ptr);
          state  <= S_EXEC;
        end
        S_EXEC: begin
          bus.rf_raddr1_o <= a_addr;
          bus.rf_raddr2_o <= b_addr;
          bus.alu_op_o    <= op;
          bus.alu_start_o <= 1'b1;
          timer           <= '0;
          state           <= S_WAIT_ALU;
        end
        // Keys are ignored while the ALU is running; a missing done aborts to IDLE.
        S_WAIT_ALU: begin
          if (bus.alu_done_pi) begin
            result         <= bus.alu_result_pi;
            bus.rf_we_o    <= 1'b1;
            bus.rf_waddr_o <= wr_ptr;
            bus.rf_wdata_o <= bus.alu_result_pi;
            state          <= S_WRITE_R;
          end else if (timer == TMR_W'(ALU_TIMEOUT - 1)) begin
            bus.error_code_o <= ERR_TIMEOUT;
            bus.busy_o       <= 1'b0;
            state            <= S_IDLE;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        S_WRITE_R: begin
          a_addr              <= wr_ptr;
          wr_ptr              <= addr_inc(wr_ptr);
          bus.display_value_o <= result;
          bus.display_en_o    <= 1'b1;
          bus.busy_o          <= 1'b0;
          state               <= S_SHOW;
        end
        S_READBACK: begin
          bus.display_value_o <= bus.rf_rdata1_pi;
          bus.display_en_o    <= 1'b1;
          if (bus.mode_pi) begin
            state <= S_IDLE;
          end else if (key_eq) begin
            rd_ptr           <= addr_dec(rd_ptr);
            bus.rf_raddr1_o  <= addr_dec(rd_ptr);
            bus.error_code_o <= ERR_NONE;
          end else if (bus.key_valid_pi) begin
            bus.error_code_o <= ERR_KEY;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_sequencer_gen.sv
// Directed bench for calc_sequencer_gen: hand-computed keypad sessions with a bench
// register file, a scripted ALU responder and immediate assertions at each check.
module tb_calc_sequencer_gen;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  int          total = 0;
  int          bad = 0;
  int          wcount = 0;
  logic [4:0]  exp_wptr = 5'd1;
  logic [15:0] mem [0:31];

  calc_sequencer_gen_if #(.DATA_W(16), .ADDR_W(5)) bus ();

  calc_sequencer_gen #(
    .DATA_W     (16),
    .ADDR_W     (5),
    .NUM_DIGITS (4),
    .ALU_TIMEOUT(64)
  ) dut (
    .clk       (clk),
    .reset_n_pi(reset_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  assign bus.rf_rdata1_pi = mem[bus.rf_raddr1_o];

  function automatic logic [4:0] wrap_inc(input logic [4:0] a);
    return (a == 5'd31) ? 5'd1 : a + 5'd1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Bench register file: records every write and checks the write-pointer sequence.
  always @(negedge clk) begin
    if (reset_n && bus.rf_we_o) begin
      check("wr_addr_seq", bus.rf_waddr_o, exp_wptr);
      check("wr_addr_nonzero", bus.rf_waddr_o != 5'd0, 1);
      mem[bus.rf_waddr_o] = bus.rf_wdata_o;
      exp_wptr = wrap_inc(exp_wptr);
      wcount++;
    end
  end

  task automatic press(input logic [3:0] k);
    @(negedge clk);
    bus.key_valid_pi = 1'b1;
    bus.key_code_pi  = k;
    @(negedge clk);
    bus.key_valid_pi = 1'b0;
    bus.key_code_pi  = 4'h0;
  endtask

  task automatic wait_start(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.alu_start_o) seen = 1'b1;
    end
    check("alu_start_seen", seen, 1);
  endtask

  task automatic run_alu(input int dly, input logic [15:0] res, input logic [3:0] exp_op,
                         input logic [4:0] exp_a, input logic [4:0] exp_b);
    bit seen;
    wait_start(seen);
    if (seen) begin
      check("alu_op", bus.alu_op_o, exp_op);
      check("alu_raddr1", bus.rf_raddr1_o, exp_a);
      check("alu_raddr2", bus.rf_raddr2_o, exp_b);
      check("busy_exec", bus.busy_o, 1);
      @(negedge clk);
      check("alu_start_pulse", bus.alu_start_o, 0);
      repeat (dly - 1) @(negedge clk);
      bus.alu_done_pi   = 1'b1;
      bus.alu_result_pi = res;
      @(negedge clk);
      bus.alu_done_pi   = 1'b0;
      bus.alu_result_pi = 16'h0;
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit          seen;
    int          n;
    int          wsave;
    logic [4:0]  a;
    logic [4:0]  b;
    logic [4:0]  rb_addr [4];
    logic [15:0] rb_val [4];

    for (int i = 0; i < 32; i++) mem[i] = 16'h0;
    bus.mode_pi       = 1'b1;
    bus.key_valid_pi  = 1'b0;
    bus.key_code_pi   = 4'h0;
    bus.alu_done_pi   = 1'b0;
    bus.alu_result_pi = 16'h0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_display", bus.display_value_o, 0);
    check("rst_display_en", bus.display_en_o, 0);
    check("rst_error", bus.error_code_o, 0);
    check("rst_busy", bus.busy_o, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_we", bus.rf_we_o, 0);
    check("idle_start", bus.alu_start_o, 0);

    // Illegal key in IDLE, then 12 + 34 = 46
    press(4'hF);
    check("idle_illegal_err", bus.error_code_o, 3'b010);
    press(4'd1);
    check("digit_clears_err", bus.error_code_o, 0);
    check("disp_1", bus.display_value_o, 1);
    press(4'd2);
    check("disp_12", bus.display_value_o, 12);
    press(4'hA);
    check("write_a_we", bus.rf_we_o, 1);
    check("write_a_addr", bus.rf_waddr_o, 1);
    check("write_a_data", bus.rf_wdata_o, 12);
    press(4'd3);
    press(4'd4);
    check("disp_34", bus.display_value_o, 34);
    press(4'hF);
    run_alu(2, 16'd46, 4'hA, 5'd1, 5'd2);
    @(negedge clk);
    check("disp_46", bus.display_value_o, 46);
    check("disp_en_46", bus.display_en_o, 1);
    check("busy_show", bus.busy_o, 0);
    check("mem1", mem[1], 12);
    check("mem2", mem[2], 34);
    check("mem3", mem[3], 46);
    check("wcount_3", wcount, 3);

    // Chain: result 46 - 6 = 40
    press(4'hB);
    press(4'd6);
    press(4'hF);
    run_alu(1, 16'd40, 4'hB, 5'd3, 5'd4);
    @(negedge clk);
    check("disp_40", bus.display_value_o, 40);
    check("mem4", mem[4], 6);
    check("mem5", mem[5], 40);

    // Digit overflow, op replacement, F in ENTER_OP
    repeat (4) press(4'd9);
    check("disp_9999", bus.display_value_o, 9999);
    check("err_ok_4digits", bus.error_code_o, 0);
    press(4'd9);
    check("err_overflow", bus.error_code_o, 3'b001);
    check("disp_hold_9999", bus.display_value_o, 9999);
    press(4'hA);
    check("op_clears_err", bus.error_code_o, 0);
    check("write_9999_addr", bus.rf_waddr_o, 6);
    check("write_9999_data", bus.rf_wdata_o, 9999);
    press(4'hC);
    press(4'hF);
    check("enter_op_eq_err", bus.error_code_o, 3'b010);
    press(4'd1);
    check("enter_b_clears_err", bus.error_code_o, 0);
    press(4'hF);
    run_alu(1, 16'd1, 4'hC, 5'd6, 5'd7);
    @(negedge clk);
    check("disp_and", bus.display_value_o, 1);
    check("mem8", mem[8], 1);

    // ALU timeout: no done for 64 cycles
    press(4'd5);
    press(4'hA);
    press(4'd5);
    press(4'hF);
    wait_start(seen);
    check("to_raddr1", bus.rf_raddr1_o, 9);
    check("to_raddr2", bus.rf_raddr2_o, 10);
    n = 0;
    while (bus.error_code_o !== 3'b100 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("timeout_cycles", n, 64);
    check("timeout_err", bus.error_code_o, 3'b100);
    check("timeout_busy", bus.busy_o, 0);
    check("timeout_no_write", wcount, 10);

    // Eight more calculations push the write pointer past 31 back to 1
    a = 5'd11;
    for (int i = 0; i < 8; i++) begin
      b = wrap_inc(a);
      press(4'(i + 1));
      press(4'hA);
      press(4'd2);
      press(4'hF);
      run_alu(1, 16'(i + 3), 4'hA, a, b);
      a = wrap_inc(wrap_inc(b));
    end
    @(negedge clk);
    check("wrap_wcount", wcount, 34);
    check("wrap_mem31", mem[31], 9);
    check("wrap_mem1", mem[1], 8);
    check("wrap_disp", bus.display_value_o, 10);

    // Readback walks 3, 2, 1, 31
    rb_addr = '{5'd3, 5'd2, 5'd1, 5'd31};
    rb_val  = '{16'd10, 16'd2, 16'd8, 16'd9};
    @(negedge clk);
    bus.mode_pi = 1'b0;
    repeat (2) @(negedge clk);
    check("rb_addr0", bus.rf_raddr1_o, rb_addr[0]);
    check("rb_val0", bus.display_value_o, rb_val[0]);
    for (int i = 1; i < 4; i++) begin
      press(4'hF);
      @(negedge clk);
      check($sformatf("rb_addr%0d", i), bus.rf_raddr1_o, rb_addr[i]);
      check($sformatf("rb_val%0d", i), bus.display_value_o, rb_val[i]);
    end
    bus.mode_pi = 1'b1;
    repeat (2) @(negedge clk);

    // Reset while waiting on the ALU
    press(4'd1);
    press(4'hA);
    press(4'd2);
    press(4'hF);
    wait_start(seen);
    @(negedge clk);
    check("pre_rst_busy", bus.busy_o, 1);
    #2 reset_n = 1'b0;
    exp_wptr = 5'd1;
    #1;
    check("mid_rst_busy", bus.busy_o, 0);
    check("mid_rst_raddr1", bus.rf_raddr1_o, 0);
    check("mid_rst_raddr2", bus.rf_raddr2_o, 0);
    check("mid_rst_op", bus.alu_op_o, 0);
    check("mid_rst_display", bus.display_value_o, 0);
    check("mid_rst_en", bus.display_en_o, 0);
    check("mid_rst_we", bus.rf_we_o, 0);
    check("mid_rst_wdata", bus.rf_wdata_o, 0);
    @(negedge clk);
    reset_n = 1'b1;
    wsave = wcount;
    repeat (10) @(negedge clk);
    check("post_rst_no_write", wcount, wsave);
    check("post_rst_busy", bus.busy_o, 0);
    press(4'd7);
    check("post_rst_disp", bus.display_value_o, 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
